// File: rtl/skein_pkg.sv
// Shared Skein constants: word width, Threefish-1024 subkey count, UBI tweak
// type/flag words and position constants, plus the tweak-schedule FSM
// encoding and the t2 recompute helper.
package skein_pkg;

   localparam int SKEIN_WORD_W          = 64;
   localparam int SKEIN1024_NUM_SUBKEYS = 21;

   // t1 type/flag words (first + final block set)
   localparam logic [63:0] T1_MSG_FIRST_FINAL = 64'hF000000000000000;
   localparam logic [63:0] T1_OUT_FIRST_FINAL = 64'hFF00000000000000;

   // t0 position values for a single-block message / output stage
   localparam logic [63:0] MSG_POS = 64'd64;
   localparam logic [63:0] OUT_POS = 64'd8;

   // tweak schedule FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Third tweak word is always derived, never trusted from the source.
   function automatic logic [SKEIN_WORD_W-1:0] tweak_t2(
      input logic [SKEIN_WORD_W-1:0] t0,
      input logic [SKEIN_WORD_W-1:0] t1
   );
      return t0 ^ t1;
   endfunction

endpackage

// File: rtl/skein_tweak_rot3.sv
// 3-word rotating tweak register.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         capture d0/d1/d2
//   rot          rotate {q0,q1,w2} <= {q1,w2,q0}
//   clr          zero all words (highest priority)
//   d0..d2       words to load
//   q0, q1       current head pair (t[s mod 3], t[(s+1) mod 3])
module skein_tweak_rot3 #(
   parameter int WORD_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              rot,
   input  logic              clr,
   input  logic [WORD_W-1:0] d0,
   input  logic [WORD_W-1:0] d1,
   input  logic [WORD_W-1:0] d2,
   output logic [WORD_W-1:0] q0,
   output logic [WORD_W-1:0] q1
);

   logic [WORD_W-1:0] w2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0 <= '0;
         q1 <= '0;
         w2 <= '0;
      end else if (clr) begin
         q0 <= '0;
         q1 <= '0;
         w2 <= '0;
      end else if (load) begin
         q0 <= d0;
         q1 <= d1;
         w2 <= d2;
      end else if (rot) begin
         q0 <= q1;
         q1 <= w2;
         w2 <= q0;
      end
   end

endmodule

// File: rtl/skein_tweak_schedule.sv
// Threefish-1024 tweak schedule: latches {t2,t1,t0}, recomputes t2 = t0^t1
// and issues the pair (t[s mod 3], t[(s+1) mod 3]) for s = 0..NUM_SUBKEYS-1
// under a valid/ready handshake. All outputs come straight from flops.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   tweak_i             {t2,t1,t0}, t0 in the low word
//   tweak_valid_i/ready_o  load handshake (ready = idle)
//   abort_i             drop the running schedule
//   sk_t0_o, sk_t1_o    tweak pair for subkey sk_idx_o
//   sk_valid_o/ready_i  subkey handshake
//   done_o              pulse after the last subkey is consumed
//   tweak_err_o         pulse when supplied t2 != t0^t1
module skein_tweak_schedule
   import skein_pkg::*;
#(
   parameter int WORD_W      = SKEIN_WORD_W,
   parameter int NUM_SUBKEYS = SKEIN1024_NUM_SUBKEYS,
   parameter int IDX_W       = $clog2(NUM_SUBKEYS)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic [3*WORD_W-1:0] tweak_i,
   input  logic                tweak_valid_i,
   output logic                tweak_ready_o,
   input  logic                abort_i,
   output logic [WORD_W-1:0]   sk_t0_o,
   output logic [WORD_W-1:0]   sk_t1_o,
   output logic [IDX_W-1:0]    sk_idx_o,
   output logic                sk_valid_o,
   input  logic                sk_ready_i,
   output logic                done_o,
   output logic                tweak_err_o
);

   logic [0:0]        state;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] t0, t1, t2_in, t2_calc;
   logic              load, step, last, kill;

   assign t0      = tweak_i[WORD_W-1:0];
   assign t1      = tweak_i[2*WORD_W-1:WORD_W];
   assign t2_in   = tweak_i[3*WORD_W-1:2*WORD_W];
   assign t2_calc = tweak_t2(t0, t1);

   assign tweak_ready_o = (state == ST_IDLE);
   assign sk_valid_o    = (state == ST_RUN);
   assign sk_idx_o      = idx;

   assign load = tweak_valid_i & tweak_ready_o;
   // abort wins over a simultaneous consume
   assign kill = sk_valid_o & abort_i;
   assign step = sk_valid_o & sk_ready_i & ~abort_i;
   assign last = step & (idx == IDX_W'(NUM_SUBKEYS-1));

   skein_tweak_rot3 #(.WORD_W(WORD_W)) u_rot (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .load  (load),
      .rot   (step),
      .clr   (kill | last),
      .d0    (t0),
      .d1    (t1),
      .d2    (t2_calc),
      .q0    (sk_t0_o),
      .q1    (sk_t1_o)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_IDLE;
         idx         <= '0;
         done_o      <= 1'b0;
         tweak_err_o <= 1'b0;
      end else begin
         done_o      <= 1'b0;
         tweak_err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  state       <= ST_RUN;
                  idx         <= '0;
                  tweak_err_o <= (t2_in != t2_calc);
               end
            end
            default: begin
               if (kill) begin
                  state <= ST_IDLE;
                  idx   <= '0;
               end else if (last) begin
                  state  <= ST_IDLE;
                  idx    <= '0;
                  done_o <= 1'b1;
               end else if (step) begin
                  idx <= idx + IDX_W'(1);
               end
            end
         endcase
      end
   end

endmodule
